// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the datapath and stage-register controls returned to it.
// master = pipeline datapath, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       halt_commit;

    logic       pipe_en;
    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_stall;
    logic       idex_flush;
    logic       exmem_stall;
    logic       exmem_flush;
    logic       memwb_stall;
    logic       memwb_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
               br_taken, mem_req, mem_ready, halt_commit,
        input  pipe_en, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_stall, memwb_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
               br_taken, mem_req, mem_ready, halt_commit,
        output pipe_en, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_stall, memwb_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch squash, memory wait,
// halt, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    pipe_hazard_ctrl_if.slave bus,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t state, state_next;

    logic memwait, loaduse, squash, any_stall;
    logic pipe_en, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, exmem_flush, memwb_stall, memwb_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        memwait = ((state == RUN) && bus.mem_req && !bus.mem_ready) ||
                  ((state == MEMWAIT) && !bus.mem_ready);
        loaduse = bus.ex_is_load && (bus.ex_rd != '0) &&
                  ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    end

    // Controls are gated by rstn so everything reads 0 while reset is held.
    always_comb begin
        state_next  = state;
        squash      = 1'b0;
        pipe_en     = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_stall = 1'b0;
        memwb_flush = 1'b0;
        if (rstn && (state != HALTED)) begin
            pipe_en    = 1'b1;
            state_next = RUN;
            if (bus.halt_commit) begin
                pipe_en    = 1'b0;
                state_next = HALTED;
            end else if (memwait) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
                state_next  = MEMWAIT;
            end else if (bus.br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                squash     = 1'b1;
            end else if (loaduse) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        bus.pipe_en     = pipe_en;
        bus.pc_stall    = pc_stall;
        bus.ifid_stall  = ifid_stall;
        bus.ifid_flush  = ifid_flush;
        bus.idex_stall  = idex_stall;
        bus.idex_flush  = idex_flush;
        bus.exmem_stall = exmem_stall;
        bus.exmem_flush = exmem_flush;
        bus.memwb_stall = memwb_stall;
        bus.memwb_flush = memwb_flush;
        any_stall = pc_stall | ifid_stall | idex_stall | exmem_stall | memwb_stall;
        halted    = (state == HALTED);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (any_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (squash && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected control vectors are queued
// as stimulus is applied and popped when the DUT outputs are sampled.
module tb_pipe_hazard_ctrl;

    // {pipe_en, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    //  exmem_stall, exmem_flush, memwb_stall, memwb_flush}
    localparam logic [9:0] C_OFF  = 10'b0000000000;
    localparam logic [9:0] C_NONE = 10'b1000000000;
    localparam logic [9:0] C_LU   = 10'b1110010000;
    localparam logic [9:0] C_BR   = 10'b1001010000;
    localparam logic [9:0] C_MW   = 10'b1110101001;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic       hlt;
        logic [9:0] ctl;
    } stim_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        halted, sat_halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  sat_stall, sat_flush;
    int          checks = 0;
    int          failures = 0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();
    pipe_hazard_ctrl_if sat_bus();

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .bus(sat_bus.slave),
        .halted(sat_halted), .stall_cnt(sat_stall), .flush_cnt(sat_flush)
    );

    function automatic logic [9:0] ctl_now();
        return {bus.pipe_en, bus.pc_stall, bus.ifid_stall, bus.ifid_flush,
                bus.idex_stall, bus.idex_flush, bus.exmem_stall, bus.exmem_flush,
                bus.memwb_stall, bus.memwb_flush};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic ld,
                                 input logic [4:0] rd, input logic br, input logic req,
                                 input logic rdy, input logic hlt, input logic [9:0] ctl);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.ld = ld; s.rd = rd;
        s.br = br; s.req = req; s.rdy = rdy; s.hlt = hlt; s.ctl = ctl;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_rs1 = s.rs1; bus.id_rs2 = s.rs2;
        bus.id_use_rs1 = s.u1; bus.id_use_rs2 = s.u2;
        bus.ex_is_load = s.ld; bus.ex_rd = s.rd;
        bus.br_taken = s.br; bus.mem_req = s.req; bus.mem_ready = s.rdy;
        bus.halt_commit = s.hlt;
        exp_q.push_back(s.ctl);
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_is_load = 1'b0; bus.ex_rd = '0; bus.br_taken = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.halt_commit = 1'b0;
        sat_bus.id_rs1 = '0; sat_bus.id_rs2 = '0; sat_bus.id_use_rs1 = 1'b0;
        sat_bus.id_use_rs2 = 1'b0; sat_bus.ex_is_load = 1'b0; sat_bus.ex_rd = '0;
        sat_bus.br_taken = 1'b0; sat_bus.mem_req = 1'b0; sat_bus.mem_ready = 1'b0;
        sat_bus.halt_commit = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [9:0] want;
        idle_inputs();
        bus.mem_req = 1'b1;
        rstn = 1'b0;
        #2;
        checks++;
        if (ctl_now() !== C_OFF) begin
            failures++; $display("FAIL reset_ctl got=%b want=%b", ctl_now(), C_OFF);
        end
        checks++;
        if (halted !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got halted=%b stall=%0d flush=%0d want 0/0/0",
                     halted, stall_cnt, flush_cnt);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (ctl_now() !== want) begin
            failures++; $display("FAIL reset_release_ctl got=%b want=%b", ctl_now(), want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        logic [9:0] want;
        int unsigned want_stall[$];
        reset_dut();
        seq.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        want_stall.push_back(1);
        seq.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        want_stall.push_back(1);
        seq.push_back(mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        want_stall.push_back(1);
        seq.push_back(mk(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        want_stall.push_back(2);
        seq.push_back(mk(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        want_stall.push_back(2);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (ctl_now() !== want) begin
                failures++; $display("FAIL load_use[%0d] ctl got=%b want=%b", i, ctl_now(), want);
            end
            @(posedge clk); #1;
            checks++;
            if (stall_cnt !== want_stall[i]) begin
                failures++;
                $display("FAIL load_use[%0d] stall_cnt got=%0d want=%0d", i, stall_cnt, want_stall[i]);
            end
        end
    endtask

    task automatic test_branch();
        stim_t seq[$];
        logic [9:0] want;
        reset_dut();
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_BR));
        seq.push_back(mk(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_BR));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE));
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (ctl_now() !== want) begin
                failures++; $display("FAIL branch[%0d] ctl got=%b want=%b", i, ctl_now(), want);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (flush_cnt !== 32'd2 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL branch_counters got flush=%0d stall=%0d want flush=2 stall=0",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        stim_t seq[$];
        logic [9:0] want;
        reset_dut();
        for (int i = 0; i < 3; i++)
            seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_MW));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (ctl_now() !== want) begin
                failures++; $display("FAIL mem_wait[%0d] ctl got=%b want=%b", i, ctl_now(), want);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++; $display("FAIL mem_wait stall_cnt got=%0d want=3", stall_cnt);
        end
    endtask

    task automatic test_branch_during_wait();
        stim_t seq[$];
        logic [9:0] want;
        reset_dut();
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_MW));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_MW));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, C_BR));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (ctl_now() !== want) begin
                failures++; $display("FAIL br_wait[%0d] ctl got=%b want=%b", i, ctl_now(), want);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin
            failures++;
            $display("FAIL br_wait counters got flush=%0d stall=%0d want flush=1 stall=2",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        logic [9:0] want;
        reset_dut();
        apply(mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, C_LU));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (ctl_now() !== want) begin
            failures++; $display("FAIL halt_pre ctl got=%b want=%b", ctl_now(), want);
        end
        @(posedge clk); #1;
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_OFF));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (ctl_now() !== want || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_commit got ctl=%b halted=%b want ctl=%b halted=0",
                     ctl_now(), halted, want);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            apply(mk(5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 5'($urandom_range(1, 31)),
                     1'($urandom), 1'b1, 1'($urandom), 1'($urandom), C_OFF));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (ctl_now() !== want || halted !== 1'b1) begin
                failures++;
                $display("FAIL halted[%0d] got ctl=%b halted=%b want ctl=%b halted=1",
                         i, ctl_now(), halted, want);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL halt_counters got stall=%0d flush=%0d want stall=1 flush=0",
                     stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_midwait();
        logic [9:0] want;
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_MW));
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (ctl_now() !== want) begin
                failures++; $display("FAIL midwait[%0d] ctl got=%b want=%b", i, ctl_now(), want);
            end
            @(posedge clk); #1;
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (ctl_now() !== C_OFF || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL midwait_reset got ctl=%b stall=%0d flush=%0d halted=%b want all 0",
                     ctl_now(), stall_cnt, flush_cnt, halted);
        end
        rstn = 1'b1;
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (ctl_now() !== want) begin
            failures++; $display("FAIL midwait_release ctl got=%b want=%b", ctl_now(), want);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++; $display("FAIL midwait_release stall_cnt got=%0d want=0", stall_cnt);
        end
    endtask

    task automatic test_saturate();
        reset_dut();
        sat_bus.mem_req = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (sat_stall !== 2'd3) begin
            failures++; $display("FAIL sat_stall got=%0d want=3", sat_stall);
        end
        sat_bus.mem_ready = 1'b1;
        sat_bus.br_taken = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (sat_flush !== 2'd3 || sat_stall !== 2'd3) begin
            failures++;
            $display("FAIL sat_flush got flush=%0d stall=%0d want flush=3 stall=3",
                     sat_flush, sat_stall);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_branch_during_wait();
        test_halt();
        test_reset_midwait();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
